// File: rtl/itr_retpc_arbiter_pkg.sv
// Shared types and constants for the interrupt return-PC write path
// (RAV / RAVW0 CSR writes from the JAL-overload logic).
package VX_gpu_pkg;

  localparam int ITR_NUM_WARPS = 4;
  localparam int ITR_XLEN      = 32;

  localparam logic [11:0] CSR_RAV   = 12'hBC0;
  localparam logic [11:0] CSR_RAVW0 = 12'hBC1;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ITR_NW_WIDTH = log2up(ITR_NUM_WARPS);

  typedef struct packed {
    logic [ITR_NW_WIDTH-1:0] wid;
    logic                    w0;
    logic [ITR_XLEN-1:0]     data;
  } itr_wr_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_BUSY = 1'b1
  } wr_state_e;

endpackage

// File: rtl/itr_retpc_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: the search starts at a rotating pointer that
// moves just past each grant the consumer actually takes.
module VX_rr_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int LOCK_ENABLE = 0,
  parameter int IDX_W       = log2up(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                grant_ready,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_index
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [IDX_W-1:0] start;

  // With locking, an unaccepted grant keeps priority until it is taken.
  if (LOCK_ENABLE != 0) begin : g_lock
    logic             held_q;
    logic [IDX_W-1:0] held_idx_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        held_q     <= 1'b0;
        held_idx_q <= '0;
      end else if (clear) begin
        held_q <= 1'b0;
      end else begin
        held_q <= grant_valid && !grant_ready;
        if (grant_valid && !grant_ready) held_idx_q <= grant_index;
      end
    end
    assign start = held_q ? held_idx_q : rr_ptr_q;
  end else begin : g_nolock
    assign start = rr_ptr_q;
  end

  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_index = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (requests[idx]) begin
        grant_valid = 1'b1;
        grant_index = IDX_W'(idx);
      end
    end
  end

  assign rr_ptr_d = (int'(grant_index) == NUM_REQS - 1) ? '0 : grant_index + IDX_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else if (clear) begin
      rr_ptr_q <= '0;
    end else if (grant_valid && grant_ready) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/itr_retpc_arbiter.sv
// Serializes per-warp overloaded-JAL return-PC captures onto the single
// RAV/RAVW0 CSR write port and tracks which warps have been serviced.
module itr_retpc_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int WARP_CNT = ITR_NUM_WARPS,
  parameter int XLEN     = ITR_XLEN,
  parameter int NW_WIDTH = log2up(WARP_CNT)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WARP_CNT-1:0]      req_valid,
  input  logic [WARP_CNT*XLEN-1:0] req_retpc,
  output logic [WARP_CNT-1:0]      req_ready,
  input  logic [WARP_CNT-1:0]      overload_en,
  input  logic [WARP_CNT-1:0]      active_wmask,
  input  logic                     clear,
  output logic                     csr_wr_valid,
  input  logic                     csr_wr_ready,
  output logic [NW_WIDTH-1:0]      csr_wr_wid,
  output logic                     csr_wr_w0,
  output logic [XLEN-1:0]          csr_wr_data,
  output logic [WARP_CNT-1:0]      served_mask,
  output logic                     all_served
);

  typedef struct packed {
    logic [NW_WIDTH-1:0] wid;
    logic                w0;
    logic [XLEN-1:0]     data;
  } wr_t;

  wr_state_e           state_q, state_d;
  wr_t                 wr_q, wr_d;
  logic [WARP_CNT-1:0] pending_q, pending_d;
  logic [WARP_CNT-1:0] served_q, served_d;
  logic                all_served_q, all_served_d;
  logic [XLEN-1:0]     pc_buf_q [WARP_CNT];

  logic [WARP_CNT-1:0] accept, in_flight, arb_req, done_mask;
  logic                csr_fire, can_load, grant_take, grant_valid;
  logic [NW_WIDTH-1:0] grant_index;

  assign csr_fire   = (state_q == WR_BUSY) && csr_wr_ready;
  assign can_load   = (state_q == WR_IDLE) || csr_fire;
  assign grant_take = grant_valid && can_load && !clear;
  assign done_mask  = csr_fire ? (WARP_CNT'(1) << wr_q.wid) : '0;
  assign in_flight  = (state_q == WR_BUSY) ? (WARP_CNT'(1) << wr_q.wid) : '0;
  assign arb_req    = pending_q & ~in_flight;

  // Served or non-overloading warps always complete; their JAL is simply dropped.
  assign req_ready = clear ? '0 : (~pending_q | ~overload_en | served_q);
  assign accept    = req_valid & req_ready & overload_en & ~served_q;

  VX_rr_arbiter #(
    .NUM_REQS   (WARP_CNT),
    .LOCK_ENABLE(0),
    .IDX_W      (NW_WIDTH)
  ) u_rr_arbiter (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .requests   (arb_req),
    .grant_ready(grant_take),
    .grant_valid(grant_valid),
    .grant_index(grant_index)
  );

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    pending_d    = (pending_q | accept) & ~done_mask;
    served_d     = served_q | done_mask;
    all_served_d = (active_wmask != '0) && (&(served_q | ~active_wmask));

    unique case (state_q)
      WR_IDLE: if (grant_take) state_d = WR_BUSY;
      WR_BUSY: if (csr_wr_ready) state_d = grant_take ? WR_BUSY : WR_IDLE;
      default: state_d = WR_IDLE;
    endcase

    if (grant_take) begin
      wr_d.wid  = grant_index;
      wr_d.w0   = (grant_index == '0);
      wr_d.data = pc_buf_q[grant_index];
    end

    // A restart drops any held write; the CSR side tolerates valid falling.
    if (clear) begin
      state_d      = WR_IDLE;
      pending_d    = '0;
      served_d     = '0;
      all_served_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WR_IDLE;
      wr_q         <= '0;
      pending_q    <= '0;
      served_q     <= '0;
      all_served_q <= 1'b0;
      for (int i = 0; i < WARP_CNT; i++) pc_buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      pending_q    <= pending_d;
      served_q     <= served_d;
      all_served_q <= all_served_d;
      for (int i = 0; i < WARP_CNT; i++) begin
        if (accept[i]) pc_buf_q[i] <= req_retpc[i*XLEN +: XLEN];
      end
    end
  end

  assign csr_wr_valid = (state_q == WR_BUSY);
  assign csr_wr_wid   = wr_q.wid;
  assign csr_wr_w0    = wr_q.w0;
  assign csr_wr_data  = wr_q.data;
  assign served_mask  = served_q;
  assign all_served   = all_served_q;

endmodule

// File: tb/tb_itr_retpc_arbiter.sv
// Directed bench for itr_retpc_arbiter: a per-cycle vector table plus
// hand-written sequences for back-pressure, single-warp latency and clear.
module tb_itr_retpc_arbiter;
  import VX_gpu_pkg::*;

  logic         clk;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [127:0] req_retpc;
  logic [3:0]   req_ready;
  logic [3:0]   overload_en;
  logic [3:0]   active_wmask;
  logic         clear;
  logic         csr_wr_valid;
  logic         csr_wr_ready;
  logic [1:0]   csr_wr_wid;
  logic         csr_wr_w0;
  logic [31:0]  csr_wr_data;
  logic [3:0]   served_mask;
  logic         all_served;

  int total = 0;
  int bad   = 0;

  itr_retpc_arbiter #(.WARP_CNT(4), .XLEN(32)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_retpc   (req_retpc),
    .req_ready   (req_ready),
    .overload_en (overload_en),
    .active_wmask(active_wmask),
    .clear       (clear),
    .csr_wr_valid(csr_wr_valid),
    .csr_wr_ready(csr_wr_ready),
    .csr_wr_wid  (csr_wr_wid),
    .csr_wr_w0   (csr_wr_w0),
    .csr_wr_data (csr_wr_data),
    .served_mask (served_mask),
    .all_served  (all_served)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         clr;
    logic         rdy;
    logic [3:0]   req;
    logic [3:0]   ovl;
    logic [3:0]   act;
    logic [127:0] pc;
    logic         e_valid;
    itr_wr_t      e_wr;
    logic [3:0]   e_ready;
    logic [3:0]   e_served;
    logic         e_all;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic clr, input logic rdy,
                              input logic [3:0] req, input logic [3:0] ovl, input logic [3:0] act,
                              input logic [127:0] pc, input logic ev, input logic [1:0] ewid,
                              input logic [31:0] edata, input logic [3:0] erdy,
                              input logic [3:0] eserved, input logic eall);
    vec_t v;
    v.rst = rst; v.clr = clr; v.rdy = rdy;
    v.req = req; v.ovl = ovl; v.act = act; v.pc = pc;
    v.e_valid   = ev;
    v.e_wr.wid  = ewid;
    v.e_wr.w0   = (ewid == 2'd0);
    v.e_wr.data = edata;
    v.e_ready   = erdy;
    v.e_served  = eserved;
    v.e_all     = eall;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid    = '0;
    req_retpc    = '0;
    clear        = 1'b0;
    csr_wr_ready = 1'b0;
    overload_en  = '0;
    active_wmask = '0;
    reset_n      = 1'b0;
    #2;
    reset_n      = 1'b1;
  endtask

  task automatic wait_valid(input int max_cyc, input int exp_lat, input string nm);
    int n;
    n = 0;
    while (csr_wr_valid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    chk({nm, " valid"}, 32'(csr_wr_valid), 32'd1);
    chk({nm, " latency"}, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = '0;
    req_retpc    = '0;
    clear        = 1'b0;
    csr_wr_ready = 1'b0;
    overload_en  = '0;
    active_wmask = '0;

    // Four warps together, repeat JAL from a served warp, then clear.
    vecs.push_back(mk(1, 0, 1, 4'hF, 4'hF, 4'hF, {32'h400, 32'h300, 32'h200, 32'h100}, 0, 0, 0, 4'hF, 4'h0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'hF, 4'hF, 128'h0, 0, 0, 0,        4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'hF, 4'hF, 128'h0, 1, 0, 32'h100,  4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'hF, 4'hF, 128'h0, 1, 1, 32'h200,  4'h1, 4'h1, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'hF, 4'hF, 128'h0, 1, 2, 32'h300,  4'h3, 4'h3, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'hF, 4'hF, 128'h0, 1, 3, 32'h400,  4'h7, 4'h7, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'hF, 4'hF, 128'h0, 0, 0, 0,        4'hF, 4'hF, 0));
    vecs.push_back(mk(0, 0, 1, 4'h4, 4'hF, 4'hF, {32'h0, 32'h999, 64'h0}, 0, 0, 0, 4'hF, 4'hF, 1));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'hF, 4'hF, 128'h0, 0, 0, 0,        4'hF, 4'hF, 1));
    vecs.push_back(mk(0, 1, 1, 4'h0, 4'hF, 4'hF, 128'h0, 0, 0, 0,        4'h0, 4'hF, 1));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'hF, 4'hF, 128'h0, 0, 0, 0,        4'hF, 4'h0, 0));
    // Warp 3 not overloading and not active.
    vecs.push_back(mk(1, 0, 1, 4'hF, 4'h7, 4'h7, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 0, 0, 4'hF, 4'h0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h7, 4'h7, 128'h0, 0, 0, 0,        4'h8, 4'h0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h7, 4'h7, 128'h0, 1, 0, 32'hA0,   4'h8, 4'h0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h7, 4'h7, 128'h0, 1, 1, 32'hA1,   4'h9, 4'h1, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h7, 4'h7, 128'h0, 1, 2, 32'hA2,   4'hB, 4'h3, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h7, 4'h7, 128'h0, 0, 0, 0,        4'hF, 4'h7, 0));
    vecs.push_back(mk(0, 0, 1, 4'h8, 4'h7, 4'h7, {32'hA3, 96'h0}, 0, 0, 0, 4'hF, 4'h7, 1));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h7, 4'h7, 128'h0, 0, 0, 0,        4'hF, 4'h7, 1));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h7, 4'h7, 128'h0, 0, 0, 0,        4'hF, 4'h7, 1));

    // Reset values while reset_n is held low.
    #12;
    chk("rst valid", 32'(csr_wr_valid), 32'd0);
    chk("rst wid", 32'(csr_wr_wid), 32'd0);
    chk("rst w0", 32'(csr_wr_w0), 32'd0);
    chk("rst data", csr_wr_data, 32'd0);
    chk("rst served", 32'(served_mask), 32'd0);
    chk("rst all", 32'(all_served), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst req_ready", 32'(req_ready), 32'hF);

    foreach (vecs[r]) begin
      if (vecs[r].rst) do_reset();
      req_valid    = vecs[r].req;
      req_retpc    = vecs[r].pc;
      overload_en  = vecs[r].ovl;
      active_wmask = vecs[r].act;
      clear        = vecs[r].clr;
      csr_wr_ready = vecs[r].rdy;
      #1;
      chk($sformatf("row%0d valid", r), 32'(csr_wr_valid), 32'(vecs[r].e_valid));
      if (vecs[r].e_valid) begin
        chk($sformatf("row%0d wid", r), 32'(csr_wr_wid), 32'(vecs[r].e_wr.wid));
        chk($sformatf("row%0d w0", r), 32'(csr_wr_w0), 32'(vecs[r].e_wr.w0));
        chk($sformatf("row%0d data", r), csr_wr_data, vecs[r].e_wr.data);
      end
      chk($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(vecs[r].e_ready));
      chk($sformatf("row%0d served", r), 32'(served_mask), 32'(vecs[r].e_served));
      chk($sformatf("row%0d all", r), 32'(all_served), 32'(vecs[r].e_all));
      tick();
    end

    // Single warp: write two cycles after accept, all_served two after acceptance.
    do_reset();
    overload_en = 4'hF; active_wmask = 4'h1; csr_wr_ready = 1'b1;
    req_valid = 4'h1; req_retpc = {96'h0, 32'h8000_0100};
    #1;
    chk("sw ready", 32'(req_ready), 32'hF);
    tick();
    req_valid = 4'h0;
    chk("sw n1 valid", 32'(csr_wr_valid), 32'd0);
    chk("sw n1 ready", 32'(req_ready), 32'hE);
    tick();
    chk("sw n2 valid", 32'(csr_wr_valid), 32'd1);
    chk("sw n2 wid", 32'(csr_wr_wid), 32'd0);
    chk("sw n2 w0", 32'(csr_wr_w0), 32'd1);
    chk("sw n2 data", csr_wr_data, 32'h8000_0100);
    tick();
    chk("sw m1 valid", 32'(csr_wr_valid), 32'd0);
    chk("sw m1 served", 32'(served_mask), 32'h1);
    chk("sw m1 all", 32'(all_served), 32'd0);
    chk("sw m1 ready", 32'(req_ready), 32'hF);
    tick();
    chk("sw m2 all", 32'(all_served), 32'd1);

    // Back-pressure: held write stays stable, then drains 1/cycle.
    tick();
    do_reset();
    overload_en = 4'hF; active_wmask = 4'hF; csr_wr_ready = 1'b0;
    req_valid = 4'hA; req_retpc = {32'h3333, 32'h0, 32'h1111, 32'h0};
    #1;
    tick();
    req_valid = 4'h0;
    chk("bp n1 ready", 32'(req_ready), 32'h5);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp hold%0d valid", k), 32'(csr_wr_valid), 32'd1);
      chk($sformatf("bp hold%0d wid", k), 32'(csr_wr_wid), 32'd1);
      chk($sformatf("bp hold%0d w0", k), 32'(csr_wr_w0), 32'd0);
      chk($sformatf("bp hold%0d data", k), csr_wr_data, 32'h1111);
      chk($sformatf("bp hold%0d ready", k), 32'(req_ready), 32'h5);
      tick();
    end
    csr_wr_ready = 1'b1;
    #1;
    chk("bp rel wid", 32'(csr_wr_wid), 32'd1);
    tick();
    chk("bp d1 valid", 32'(csr_wr_valid), 32'd1);
    chk("bp d1 wid", 32'(csr_wr_wid), 32'd3);
    chk("bp d1 data", csr_wr_data, 32'h3333);
    chk("bp d1 served", 32'(served_mask), 32'h2);
    chk("bp d1 ready", 32'(req_ready), 32'h7);
    tick();
    chk("bp d2 valid", 32'(csr_wr_valid), 32'd0);
    chk("bp d2 served", 32'(served_mask), 32'hA);
    chk("bp d2 ready", 32'(req_ready), 32'hF);

    // Clear while BUSY with two more entries pending, racing a CSR acceptance.
    tick();
    do_reset();
    overload_en = 4'hF; active_wmask = 4'hF; csr_wr_ready = 1'b0;
    req_valid = 4'h7; req_retpc = {32'h0, 32'h2C, 32'h1C, 32'h0C};
    #1;
    tick();
    req_valid = 4'h0;
    wait_valid(6, 1, "clr first");
    chk("clr held wid", 32'(csr_wr_wid), 32'd0);
    tick();
    clear = 1'b1; csr_wr_ready = 1'b1;
    #1;
    chk("clr ready", 32'(req_ready), 32'h0);
    tick();
    clear = 1'b0; csr_wr_ready = 1'b0;
    #1;
    chk("clr c1 valid", 32'(csr_wr_valid), 32'd0);
    chk("clr c1 served", 32'(served_mask), 32'h0);
    chk("clr c1 all", 32'(all_served), 32'd0);
    chk("clr c1 ready", 32'(req_ready), 32'hF);
    tick();
    chk("clr c2 valid", 32'(csr_wr_valid), 32'd0);
    req_valid = 4'h3; req_retpc = {64'h0, 32'hD1, 32'hD0}; csr_wr_ready = 1'b1;
    #1;
    tick();
    req_valid = 4'h0;
    tick();
    chk("clr r1 valid", 32'(csr_wr_valid), 32'd1);
    chk("clr r1 wid", 32'(csr_wr_wid), 32'd0);
    chk("clr r1 data", csr_wr_data, 32'hD0);
    tick();
    chk("clr r2 wid", 32'(csr_wr_wid), 32'd1);
    chk("clr r2 data", csr_wr_data, 32'hD1);
    tick();
    chk("clr r3 valid", 32'(csr_wr_valid), 32'd0);
    chk("clr r3 served", 32'(served_mask), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/itr_retpc_arbiter.md
# itr_retpc_arbiter

Serializes the per-warp "first JAL out of the kernel scheduler" return-PC captures from the execute stage into the single CSR write port of the interrupt controller. The RAV and RAVW0 registers in the interrupt controller accept at most one write per cycle. Several warps can hit an overloaded JAL in the same cycle, so this block buffers one capture per warp and grants the write port round-robin. It tracks which warps have been serviced and signals when JAL overloading can be switched off. It sits between the execute-stage JAL-overload logic and the interrupt controller.

## Interface
Parameters:
- WARP_CNT, `NUM_WARPS: number of warps; one request slot per warp.
- XLEN, `XLEN: return-PC width.
- NW_WIDTH, `LOG2UP(WARP_CNT): warp-id width.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  WARP_CNT  per-warp capture request (overloaded JAL committing).
- req_retpc  in  WARP_CNT*XLEN  per-warp real return PC; warp i at [i*XLEN +: XLEN].
- req_ready  out  WARP_CNT  per-warp acceptance; the commit of warp i stalls while low.
- overload_en  in  WARP_CNT  JAL overloading is active for warp i.
- active_wmask  in  WARP_CNT  warps that must be serviced before completion.
- clear  in  1  synchronous restart of the servicing session.
- csr_wr_valid  out  1  CSR write request.
- csr_wr_ready  in  1  CSR write accepted.
- csr_wr_wid  out  NW_WIDTH  warp of the write.
- csr_wr_w0  out  1  write targets RAVW0 (wid==0), else RAV.
- csr_wr_data  out  XLEN  return PC.
- served_mask  out  WARP_CNT  warps whose return PC has been written.
- all_served  out  1  every active warp has been served; drives the JALOL clear.

## Operation
- Per-warp state: pending[i] (1 bit) and pc_buf[i] (XLEN).
- req_ready[i] = !clear & (!pending[i] | !overload_en[i] | served_mask[i]).
- Accept: req_valid[i] & req_ready[i] & overload_en[i] & !served_mask[i] sets pending[i] and loads pc_buf[i].
- Handshakes that do not meet the accept condition complete immediately and are dropped. This covers a request when not overloading and a repeat JAL from a warp already served.
- Arbiter: round-robin over pending & ~in_flight, starting at rr_ptr.
  - On a grant to warp g, rr_ptr <= (g+1) mod WARP_CNT.
  - No wrap overflow for non-power-of-2 WARP_CNT.
- Output stage FSM, two states:
  - IDLE: no entry held; csr_wr_valid=0. A grant loads the output registers and the FSM goes to BUSY.
  - BUSY: csr_wr_valid=1 with stable wid/w0/data until csr_wr_ready.
  - On acceptance: clear pending[wid], set served_mask[wid]. In the same cycle, take the next grant if one exists (stay BUSY), else go to IDLE. Back-to-back writes run at 1/cycle.
- in_flight excludes the held warp from the arbiter.
- all_served is registered: (active_wmask != 0) & &(served_mask | ~active_mask).
- clear, with priority over everything else in the same cycle:
  - pending, served_mask, rr_ptr and all_served go to 0.
  - The FSM goes to IDLE, even mid-handshake. The held write is dropped, and the CSR side must tolerate valid falling.
- Reset (async): every register is 0. Outputs: csr_wr_valid=0, wid=0, w0=0, data=0, served_mask=0, all_served=0. req_ready is all-ones once reset_n is high.

## Timing
- Accept in cycle N → pending at N+1 → grant/load at end of N+1 → csr_wr_valid in N+2. Minimum latency is 2 cycles.
- Same warp: req_ready[i] is low from N+1 until the cycle after its CSR acceptance. There is no combinational path req_valid→req_ready.
- After the final acceptance in cycle M, served_mask updates at M+1 and all_served rises at M+2.
- A request and a CSR acceptance for the same warp in the same cycle are impossible by the req_ready rule. A request for warp j and the acceptance for warp k≠j are both honoured.
- Reset asserted mid-operation clears state immediately. Deassertion is synchronized externally via the standard reset relay.

## Structure
- Put the itr_wr_t struct {wid, w0, data} in VX_gpu_pkg, alongside the interrupt CSR address constants (RAV, RAVW0).
- Use a single sub-module, VX_rr_arbiter (existing generic round-robin arbiter, NUM_REQS=WARP_CNT, LOCK_ENABLE=0). Per-warp buffers and the output FSM are local.

## Test plan
- Single warp: WARP_CNT=4, overload_en=4'hF, active_wmask=4'h1. Warp 0 requests retpc=0x8000_0100 → one write 2 cycles later with wid=0, w0=1, data=0x8000_0100. served_mask=4'h1; all_served=1 two cycles after acceptance.
- Four warps request together with PCs 0x100/0x200/0x300/0x400 and csr_wr_ready=1 → writes on 4 consecutive cycles in order 0,1,2,3. w0 is high only for the first. all_served rises after the fourth.
- Back-pressure: csr_wr_ready=0 for 5 cycles → csr_wr_valid held with stable data, and req_ready low for the pending warps. Release → writes drain 1/cycle.
- Repeat JAL from warp 2 after it has been served → accepted with req_ready=1 and no CSR write generated.
- overload_en[3]=0 with req_valid[3]=1 → no pending entry and no write; all_served ignores warp 3 when active_wmask[3]=0.
- clear asserted while BUSY with 2 entries pending → next cycle: csr_wr_valid=0, served_mask=0, all_served=0, rr_ptr=0. A new request after that is serviced normally.
